// File: rtl/msx2_ram_mapper_port.sv
// MSX2 RAM mapper to SDRAM responder: one outstanding request, strobe at T -> ram_rd/ram_wr at T+1, data at ready+1.
// Backpressure: cpu_wait stretches the CPU cycle until ready or timeout; access must drop between transactions.
module msx2_ram_mapper_port #(
   parameter int unsigned       ADDR_W   = 27,
   parameter logic [ADDR_W-1:0] RAM_BASE = '0,
   parameter logic [7:0]        TIMEOUT  = 8'd255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_mreq,
   input  logic              cpu_rd,
   input  logic              cpu_wr,
   input  logic              cpu_rfsh,
   input  logic              en,
   input  logic [21:0]       mapper_addr,
   input  logic [7:0]        cpu_dout,
   output logic [7:0]        cpu_din,
   output logic              cpu_wait,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_dout,
   output logic              ram_rd,
   output logic              ram_wr,
   input  logic [7:0]        ram_din,
   input  logic              ram_ready,
   output logic              ram_err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   logic [1:0]        state_q, state_d;
   logic              access_q;
   logic [7:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        dout_q, dout_d;
   logic              is_wr_q, is_wr_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic [7:0]        din_q, din_d;
   logic              err_q, err_d;

   logic access;
   logic new_access;
   logic done;

   assign access     = cpu_mreq & en & ~cpu_rfsh & (cpu_rd | cpu_wr);
   assign new_access = access & ~access_q;
   // ready takes priority over a simultaneous timeout
   assign done       = ram_ready | (cnt_q == TIMEOUT);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      dout_d  = dout_q;
      is_wr_d = is_wr_q;
      din_d   = din_q;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (new_access) begin
               addr_d  = RAM_BASE + ADDR_W'(mapper_addr);
               dout_d  = cpu_dout;
               is_wr_d = cpu_wr;
               rd_d    = ~cpu_wr;
               wr_d    = cpu_wr;
               cnt_d   = 8'd0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + 8'd1;
            if (done) begin
               err_d = ~ram_ready;
               din_d = (ram_ready && !is_wr_q) ? ram_din : 8'hFF;
               if (access) begin
                  state_d = S_HOLD;
               end else begin
                  din_d   = 8'hFF;
                  state_d = S_IDLE;
               end
            end
         end
         S_HOLD: begin
            if (!access) begin
               din_d   = 8'hFF;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         access_q <= 1'b0;
         cnt_q    <= 8'd0;
         addr_q   <= '0;
         dout_q   <= 8'd0;
         is_wr_q  <= 1'b0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         din_q    <= 8'hFF;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         access_q <= access;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         dout_q   <= dout_d;
         is_wr_q  <= is_wr_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         din_q    <= din_d;
         err_q    <= err_d;
      end
   end

   assign cpu_wait = ((state_q == S_IDLE) && new_access) || (state_q == S_WAIT);
   assign cpu_din  = din_q;
   assign ram_addr = addr_q;
   assign ram_dout = dout_q;
   assign ram_rd   = rd_q;
   assign ram_wr   = wr_q;
   assign ram_err  = err_q;

endmodule

// File: tb/tb_msx2_ram_mapper_port.sv
// Bench for msx2_ram_mapper_port: transaction-level reference model, per-cycle compare, directed plus random traffic.
module tb_msx2_ram_mapper_port;

   localparam logic [26:0] BASE = 27'h100000;
   localparam int          TO   = 20;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_mreq = 1'b0, cpu_rd = 1'b0, cpu_wr = 1'b0, cpu_rfsh = 1'b0, en = 1'b0;
   logic [21:0] mapper_addr = '0;
   logic [7:0]  cpu_dout = '0;
   logic [7:0]  cpu_din;
   logic        cpu_wait;
   logic [26:0] ram_addr;
   logic [7:0]  ram_dout;
   logic        ram_rd, ram_wr, ram_err;
   logic [7:0]  ram_din = '0;
   logic        ram_ready = 1'b0;

   msx2_ram_mapper_port #(.ADDR_W(27), .RAM_BASE(BASE), .TIMEOUT(8'(TO))) dut (
      .clk(clk), .reset(reset), .cpu_mreq(cpu_mreq), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
      .cpu_rfsh(cpu_rfsh), .en(en), .mapper_addr(mapper_addr), .cpu_dout(cpu_dout),
      .cpu_din(cpu_din), .cpu_wait(cpu_wait), .ram_addr(ram_addr), .ram_dout(ram_dout),
      .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_din(ram_din), .ram_ready(ram_ready), .ram_err(ram_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic acc_now();
      return cpu_mreq & en & ~cpu_rfsh & (cpu_rd | cpu_wr);
   endfunction

   // Reference model: one outstanding transaction, its age, and whether the result is being held.
   logic        m_busy = 0, m_hold = 0, m_prev = 0, m_is_wr = 0;
   logic        m_rdp = 0, m_wrp = 0, m_err = 0;
   int          m_age = 0;
   logic [26:0] m_addr = '0;
   logic [7:0]  m_dout = '0, m_din = 8'hFF;
   logic        cmp_en = 0;

   always @(posedge clk) begin : model
      logic a;
      a = acc_now();
      m_rdp = 0; m_wrp = 0; m_err = 0;
      if (reset) begin
         m_busy = 0; m_hold = 0; m_prev = 0; m_age = 0;
         m_addr = '0; m_dout = '0; m_din = 8'hFF;
      end else begin
         if (m_busy) begin
            if (ram_ready) begin
               m_busy = 0; m_hold = a;
               m_din  = !a ? 8'hFF : (m_is_wr ? m_din : ram_din);
            end else if (m_age == TO) begin
               m_busy = 0; m_hold = a; m_err = 1; m_din = 8'hFF;
            end else begin
               m_age++;
            end
         end else if (m_hold) begin
            if (!a) begin m_hold = 0; m_din = 8'hFF; end
         end else if (a && !m_prev) begin
            m_addr  = BASE + {5'd0, mapper_addr};
            m_dout  = cpu_dout;
            m_is_wr = cpu_wr;
            m_rdp   = !cpu_wr;
            m_wrp   = cpu_wr;
            m_busy  = 1;
            m_age   = 0;
         end
         m_prev = a;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cpu_din", 32'(cpu_din), 32'(m_din));
         chk("ram_rd", 32'(ram_rd), 32'(m_rdp));
         chk("ram_wr", 32'(ram_wr), 32'(m_wrp));
         chk("ram_err", 32'(ram_err), 32'(m_err));
         chk("ram_addr", 32'(ram_addr), 32'(m_addr));
         chk("ram_dout", 32'(ram_dout), 32'(m_dout));
         #3;
         chk("cpu_wait", 32'(cpu_wait), 32'(m_busy | (!m_hold & acc_now() & !m_prev)));
      end
   end

   int rd_n = 0, wr_n = 0, err_n = 0;
   always @(negedge clk) begin
      rd_n  = rd_n + int'(ram_rd);
      wr_n  = wr_n + int'(ram_wr);
      err_n = err_n + int'(ram_err);
   end

   // SDRAM responder: ready resp_delay cycles after the request pulse (negative = never), plus stray readies.
   int         resp_delay = -1;
   int         pend = -1;
   logic       force_rdy = 0;
   logic [7:0] rd_data = '0;
   always @(negedge clk) begin
      if (m_rdp || m_wrp) pend = resp_delay;
      ram_ready = force_rdy | (pend == 0);
      if (pend >= 0) pend--;
      ram_din = rd_data;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drop();
      cpu_mreq = 0; cpu_rd = 0; cpu_wr = 0;
   endtask

   int r0, e0;

   initial begin
      tick(1);
      cmp_en = 1;
      tick(1);
      reset = 0;
      chk("rst_cpu_din", 32'(cpu_din), 32'h FF);
      chk("rst_ram_addr", 32'(ram_addr), 32'h0);
      chk("rst_ram_rd", 32'(ram_rd), 32'h0);
      tick(1);

      // read: 0x100000 + 0x0C123, ready 3 cycles after the request
      rd_data = 8'h5A; resp_delay = 3; r0 = rd_n;
      en = 1; cpu_mreq = 1; cpu_rd = 1; mapper_addr = 22'h0C123;
      #3 chk("t1_wait_first_cycle", 32'(cpu_wait), 32'h1);
      tick(1);
      chk("t1_rd_pulse", 32'(ram_rd), 32'h1);
      chk("t1_addr", 32'(ram_addr), 32'h10C123);
      tick(3);
      #3 chk("t1_wait_at_ready", 32'(cpu_wait), 32'h1);
      tick(1);
      chk("t1_data", 32'(cpu_din), 32'h5A);
      #3 chk("t1_wait_released", 32'(cpu_wait), 32'h0);
      tick(2);
      chk("t1_data_held", 32'(cpu_din), 32'h5A);
      drop();
      tick(1);
      chk("t1_data_release", 32'(cpu_din), 32'hFF);
      chk("t1_one_pulse", 32'(rd_n - r0), 32'h1);
      tick(2);

      // write with rd and wr both high; 0x100000 + 0x3FFFFF = 0x4FFFFF
      resp_delay = 1; r0 = rd_n;
      cpu_mreq = 1; cpu_rd = 1; cpu_wr = 1; cpu_dout = 8'hA7; mapper_addr = 22'h3FFFFF;
      tick(1);
      chk("t2_wr_pulse", 32'(ram_wr), 32'h1);
      chk("t2_dout", 32'(ram_dout), 32'hA7);
      chk("t2_addr", 32'(ram_addr), 32'h4FFFFF);
      tick(3);
      chk("t2_din_ff", 32'(cpu_din), 32'hFF);
      chk("t2_no_read", 32'(rd_n - r0), 32'h0);
      drop();
      tick(2);

      // timeout
      resp_delay = -1;
      cpu_mreq = 1; cpu_rd = 1; mapper_addr = 22'h00042;
      tick(1);
      e0 = err_n;
      tick(TO);
      chk("t3_no_err_yet", 32'(ram_err), 32'h0);
      #3 chk("t3_wait_still", 32'(cpu_wait), 32'h1);
      tick(1);
      chk("t3_err_pulse", 32'(ram_err), 32'h1);
      chk("t3_din_ff", 32'(cpu_din), 32'hFF);
      #3 chk("t3_wait_dropped", 32'(cpu_wait), 32'h0);
      rd_data = 8'h11; force_rdy = 1;
      tick(1);
      force_rdy = 0;
      tick(2);
      chk("t3_late_ready_ignored", 32'(cpu_din), 32'hFF);
      chk("t3_err_once", 32'(err_n - e0), 32'h1);
      drop();
      tick(2);

      // ready in the same cycle the counter reaches the limit
      resp_delay = TO; rd_data = 8'h3C;
      cpu_mreq = 1; cpu_rd = 1; mapper_addr = 22'h12345;
      tick(1);
      e0 = err_n;
      tick(TO + 1);
      chk("t6_data", 32'(cpu_din), 32'h3C);
      tick(2);
      chk("t6_no_err", 32'(err_n - e0), 32'h0);
      drop();
      tick(2);

      // filters: refresh, then slot not selected
      r0 = rd_n;
      cpu_mreq = 1; cpu_rd = 1; cpu_rfsh = 1;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         #3 chk("t4_rfsh_wait", 32'(cpu_wait), 32'h0);
      end
      cpu_rfsh = 0; en = 0;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         #3 chk("t4_en_wait", 32'(cpu_wait), 32'h0);
      end
      chk("t4_filtered_none", 32'(rd_n - r0), 32'h0);
      drop(); en = 1;
      tick(1);
      resp_delay = 2; r0 = rd_n;
      cpu_mreq = 1; cpu_rd = 1;
      tick(10);
      drop();
      tick(2);
      chk("t4_held_one_req", 32'(rd_n - r0), 32'h1);

      // reset two cycles into WAIT; the ready that follows must be ignored
      resp_delay = 5; rd_data = 8'h77;
      cpu_mreq = 1; cpu_rd = 1; mapper_addr = 22'h00777;
      tick(3);
      reset = 1; drop();
      tick(1);
      reset = 0; r0 = rd_n;
      chk("t5_din", 32'(cpu_din), 32'hFF);
      chk("t5_addr", 32'(ram_addr), 32'h0);
      chk("t5_rd", 32'(ram_rd), 32'h0);
      chk("t5_err", 32'(ram_err), 32'h0);
      #3 chk("t5_wait", 32'(cpu_wait), 32'h0);
      tick(5);
      chk("t5_ready_ignored", 32'(cpu_din), 32'hFF);
      chk("t5_no_reissue", 32'(rd_n - r0), 32'h0);

      // random traffic against the model
      for (int t = 0; t < 250; t++) begin
         int kind, hold, gap;
         resp_delay  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TO + 2));
         rd_data     = 8'($urandom);
         mapper_addr = 22'($urandom);
         cpu_dout    = 8'($urandom);
         kind        = int'($urandom_range(0, 2));
         cpu_rd      = (kind != 1);
         cpu_wr      = (kind != 0);
         cpu_rfsh    = ($urandom_range(0, 9) == 0);
         en          = ($urandom_range(0, 9) != 0);
         cpu_mreq    = 1;
         hold        = int'($urandom_range(1, TO + 6));
         for (int c = 0; c < hold; c++) begin
            tick(1);
            force_rdy = ($urandom_range(0, 19) == 0);
            reset     = ($urandom_range(0, 199) == 0);
         end
         reset = 0;
         drop();
         cpu_rfsh = 0;
         gap = int'($urandom_range(1, 4));
         for (int c = 0; c < gap; c++) begin
            tick(1);
            force_rdy = ($urandom_range(0, 19) == 0);
         end
         force_rdy = 0;
      end

      tick(TO + 4);
      cmp_en = 0;
      tick(1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
